snake_game_sequencer: RTL and testbench

Top-level game controller for the snake design. It takes the debounced direction and pause levels from the button block, runs the TITLE/PLAY/PAUSE/OVER screen state machine, and divides the system clock into move steps. Each step is issued to the snake datapath through a step/done handshake, and the next step is held off until the datapath finishes. It also tracks score and shortens the step period as food is eaten.

---
 rtl/snake_game_sequencer.sv | 178 +++++++++++++++++
 tb/tb_snake_game_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer
//   Top-level game controller for the snake design. It runs the screen state
//   machine (TITLE/PLAY/PAUSE/OVER) and divides clk into move steps. Each step
//   goes to the datapath through a step/done handshake. It also tracks the
//   score and, optionally, shortens the step period as food is eaten.
//
//   Optional feature macro: SNAKE_SPEEDUP_EN
//     When it is defined, each accepted food sets
//     period <= max(period - TICK_DEC, TICK_MIN).
//     When it is undefined, the period stays at TICK_INIT for the whole game.
//
// Ports
//   clk         in   system clock; all logic runs on its rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   start/continue level; only its rising edge acts
//   move_dir    in   requested direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
//   pause_in    in   pause level (high = paused)
//   step_done   in   one-cycle pulse: the datapath has finished the step
//   food_eaten  in   qualifier of step_done
//   collision   in   qualifier of step_done
//   step        out  one-cycle step request
//   step_dir    out  direction for the current step, held until the next step
//   screen      out  0 TITLE, 1 PLAY, 2 PAUSE, 3 OVER
//   score       out  food count, saturating at 255
//   busy        out  high from step until step_done is accepted
module snake_game_sequencer #(
  parameter int unsigned TICK_INIT = 2500000,
  parameter int unsigned TICK_DEC  = 100000,
  parameter int unsigned TICK_MIN  = 500000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] move_dir,
  input  logic       pause_in,
  input  logic       step_done,
  input  logic       food_eaten,
  input  logic       collision,
  output logic       step,
  output logic [1:0] step_dir,
  output logic [1:0] screen,
  output logic [7:0] score,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_TITLE = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } screen_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

`ifdef SNAKE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [CNT_W-1:0] P_INIT   = CNT_W'(TICK_INIT);
  localparam logic [CNT_W-1:0] P_DEC    = CNT_W'(TICK_DEC);
  localparam logic [CNT_W-1:0] P_MIN    = CNT_W'(TICK_MIN);
  // The subtraction is only taken when it cannot go below TICK_MIN.
  localparam logic [CNT_W-1:0] P_THRESH = CNT_W'(TICK_MIN + TICK_DEC);

  screen_e          state_q;
  logic             start_q;
  logic             step_q;
  logic [1:0]       step_dir_q;
  logic [7:0]       score_q;
  logic             busy_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start_rise;
  logic             done_acc;
  logic             coll_acc;
  logic             terminal;
  logic [7:0]       score_d;
  logic [CNT_W-1:0] period_d;

  always_comb begin
    start_rise = start & ~start_q;
    // A step_done with no step outstanding is ignored.
    done_acc   = step_done & busy_q;
    coll_acc   = done_acc & collision;
    terminal   = (cnt_q == (period_q - 1'b1));
    score_d    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    period_d   = period_q;
    if (SPEEDUP) begin
      period_d = (period_q >= P_THRESH) ? (period_q - P_DEC) : P_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_TITLE;
      start_q    <= 1'b0;
      step_q     <= 1'b0;
      step_dir_q <= DIR_RIGHT;
      score_q    <= '0;
      busy_q     <= 1'b0;
      period_q   <= P_INIT;
      cnt_q      <= '0;
    end else begin
      start_q <= start;
      step_q  <= 1'b0;

      if (done_acc) begin
        busy_q <= 1'b0;
        if (food_eaten) begin
          score_q  <= score_d;
          period_q <= period_d;
        end
      end

      unique case (state_q)
        S_TITLE: begin
          if (start_rise) begin
            state_q    <= S_PLAY;
            score_q    <= '0;
            period_q   <= P_INIT;
            cnt_q      <= '0;
            step_dir_q <= DIR_RIGHT;
          end
        end
        S_PLAY: begin
          // Collision beats pause; pause suppresses a step reaching terminal
          // count on the same edge because the counter branch is skipped.
          if (coll_acc) begin
            state_q <= S_OVER;
            cnt_q   <= '0;
          end else if (pause_in) begin
            state_q <= S_PAUSE;
          end else if (!busy_q) begin
            if (terminal) begin
              step_q     <= 1'b1;
              step_dir_q <= move_dir;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (coll_acc) begin
            state_q <= S_OVER;
            cnt_q   <= '0;
          end else if (!pause_in) begin
            state_q <= S_PLAY;
          end
        end
        S_OVER: begin
          if (start_rise) begin
            state_q <= S_TITLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= S_TITLE;
      endcase
    end
  end

  assign step     = step_q;
  assign step_dir = step_dir_q;
  assign screen   = state_q;
  assign score    = score_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Testbench for snake_game_sequencer with TICK_INIT=10, TICK_DEC=3, TICK_MIN=4.
// Expected step events are queued when the stimulus that causes them is
// driven, and popped when the DUT raises step.
module tb_snake_game_sequencer;

`ifdef SNAKE_SPEEDUP_EN
  localparam int G1 = 7;
  localparam int G2 = 4;
  localparam int G3 = 4;
`else
  localparam int G1 = 10;
  localparam int G2 = 10;
  localparam int G3 = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] move_dir;
  logic       pause_in;
  logic       step_done;
  logic       food_eaten;
  logic       collision;
  logic       step;
  logic [1:0] step_dir;
  logic [1:0] screen;
  logic [7:0] score;
  logic       busy;

  snake_game_sequencer #(
    .TICK_INIT(10),
    .TICK_DEC (3),
    .TICK_MIN (4),
    .CNT_W    (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .move_dir  (move_dir),
    .pause_in  (pause_in),
    .step_done (step_done),
    .food_eaten(food_eaten),
    .collision (collision),
    .step      (step),
    .step_dir  (step_dir),
    .screen    (screen),
    .score     (score),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         gap;
    logic [1:0] dir;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_step(input string tag, input int gap, input logic [1:0] dir);
    exp_t e;
    e.tag = tag;
    e.gap = gap;
    e.dir = dir;
    sb.push_back(e);
  endtask

  // Counts edges from the current reference point until step is seen.
  task automatic wait_step(input int budget);
    exp_t e;
    int   n;
    bit   seen;
    e    = sb.pop_front();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (step === 1'b1) seen = 1'b1;
    end
    chk({e.tag, "_gap"}, seen ? n : -1, e.gap);
    chk({e.tag, "_dir"}, {30'd0, step_dir}, {30'd0, e.dir});
    chk({e.tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic do_done(input logic food, input logic coll, input int exp_score,
                         input int exp_screen, input string tag);
    step_done  = 1'b1;
    food_eaten = food;
    collision  = coll;
    tick();
    step_done  = 1'b0;
    food_eaten = 1'b0;
    collision  = 1'b0;
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
    chk({tag, "_step"},   {31'd0, step}, 32'd0);
    chk({tag, "_score"},  {24'd0, score}, exp_score);
    chk({tag, "_screen"}, {30'd0, screen}, exp_screen);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n      = 1'b0;
    start      = 1'b0;
    move_dir   = 2'd2;
    pause_in   = 1'b0;
    step_done  = 1'b0;
    food_eaten = 1'b0;
    collision  = 1'b0;

    // Reset values
    #12;
    chk("rst_screen", {30'd0, screen}, 32'd0);
    chk("rst_step",   {31'd0, step}, 32'd0);
    chk("rst_dir",    {30'd0, step_dir}, 32'd3);
    chk("rst_score",  {24'd0, score}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_screen", {30'd0, screen}, 32'd0);

    // 1: start edge -> PLAY next edge, first step 10 edges later, RIGHT
    move_dir = 2'd3;
    start    = 1'b1;
    push_step("t1_first", 10, 2'd3);
    tick();
    chk("t1_play", {30'd0, screen}, 32'd1);
    start = 1'b0;
    wait_step(30);

    // 2: step_done 5 cycles after step, next step 10 later with new dir
    move_dir = 2'd0;
    repeat (4) tick();
    chk("t2_busy_held", {31'd0, busy}, 32'd1);
    do_done(1'b0, 1'b0, 0, 1, "t2_done");
    push_step("t2_next", 10, 2'd0);
    wait_step(30);

    // 4: pause with the counter at 6, hold 50 cycles, resume -> step in 4
    do_done(1'b0, 1'b0, 0, 1, "t4_done");
    repeat (6) tick();
    pause_in = 1'b1;
    tick();
    chk("t4_paused", {30'd0, screen}, 32'd2);
    cnt = 0;
    repeat (50) begin
      tick();
      if (step !== 1'b0) cnt++;
    end
    chk("t4_nostep", cnt, 32'd0);
    chk("t4_still_paused", {30'd0, screen}, 32'd2);
    move_dir = 2'd2;
    pause_in = 1'b0;
    tick();
    chk("t4_resumed", {30'd0, screen}, 32'd1);
    push_step("t4_resume", 4, 2'd2);
    wait_step(20);

    // 3: three foods; spacing 7,4,4 with speedup, 10 without
    move_dir = 2'd1;
    do_done(1'b1, 1'b0, 1, 1, "t3_food1");
    push_step("t3_gap1", G1, 2'd1);
    wait_step(30);
    do_done(1'b1, 1'b0, 2, 1, "t3_food2");
    push_step("t3_gap2", G2, 2'd1);
    wait_step(30);
    do_done(1'b1, 1'b0, 3, 1, "t3_food3");
    push_step("t3_gap3", G3, 2'd1);
    wait_step(30);

    // 5: collision with food -> OVER, score still counts; held start -> TITLE once
    do_done(1'b1, 1'b1, 4, 3, "t5_coll");
    start = 1'b1;
    tick();
    chk("t5_title", {30'd0, screen}, 32'd0);
    cnt = 0;
    repeat (19) begin
      tick();
      if (screen !== 2'd0 || step !== 1'b0) cnt++;
    end
    chk("t5_title_hold", cnt, 32'd0);
    start = 1'b0;
    tick();

    // 6: reset while busy, then a stray step_done is ignored
    start = 1'b1;
    tick();
    chk("t6_play", {30'd0, screen}, 32'd1);
    chk("t6_score_clr", {24'd0, score}, 32'd0);
    start = 1'b0;
    push_step("t6_first", 10, 2'd1);
    wait_step(30);
    do_done(1'b1, 1'b0, 1, 1, "t6_food");
    push_step("t6_second", G1, 2'd1);
    wait_step(30);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_screen", {30'd0, screen}, 32'd0);
    chk("t6_rst_busy",   {31'd0, busy}, 32'd0);
    chk("t6_rst_step",   {31'd0, step}, 32'd0);
    chk("t6_rst_dir",    {30'd0, step_dir}, 32'd3);
    chk("t6_rst_score",  {24'd0, score}, 32'd0);
    tick();
    rst_n = 1'b1;
    do_done(1'b1, 1'b0, 0, 0, "t6_stray");
    cnt = 0;
    repeat (15) begin
      tick();
      if (step !== 1'b0 || busy !== 1'b0) cnt++;
    end
    chk("t6_quiet", cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
